// File: rtl/ibex_rf_write_ctrl_if.sv
// Register file write-port bundle: the writeback and loader request channels,
// the clear-pass trigger and status, and the registered W1 write port.
interface ibex_rf_write_ctrl_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 wb_req_i;
  logic [4:0]           wb_addr_i;
  logic [DataWidth-1:0] wb_data_i;
  logic                 wb_gnt_o;
  logic                 dbg_req_i;
  logic [4:0]           dbg_addr_i;
  logic [DataWidth-1:0] dbg_data_i;
  logic                 dbg_gnt_o;
  logic                 init_start_i;
  logic                 busy_o;
  logic [4:0]           waddr_a_o;
  logic [DataWidth-1:0] wdata_a_o;
  logic                 we_a_o;

  modport master (
    output wb_req_i, wb_addr_i, wb_data_i, dbg_req_i, dbg_addr_i, dbg_data_i, init_start_i,
    input  wb_gnt_o, dbg_gnt_o, busy_o, waddr_a_o, wdata_a_o, we_a_o
  );

  modport slave (
    input  wb_req_i, wb_addr_i, wb_data_i, dbg_req_i, dbg_addr_i, dbg_data_i, init_start_i,
    output wb_gnt_o, dbg_gnt_o, busy_o, waddr_a_o, wdata_a_o, we_a_o
  );
endinterface

// File: rtl/ibex_rf_write_ctrl.sv
// Write-port controller for the flop-based register file: runs clear passes and
// arbitrates W1 between core writeback and a starvation-bounded debug loader.
module ibex_rf_write_ctrl #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          MaxStall    = 4,
  parameter bit                   InitOnReset = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_rf_write_ctrl_if.slave rf
);

  localparam logic [4:0] AddrMask = RV32E ? 5'h0F : 5'h1F;
  localparam logic [4:0] LastIdx  = RV32E ? 5'd15 : 5'd31;
  localparam logic [3:0] StallMax = 4'(MaxStall);

  typedef enum logic {
    CLR,
    ARB
  } state_e;

  localparam state_e ResetState = InitOnReset ? CLR : ARB;

  state_e               state_q, state_d;
  logic [4:0]           clr_idx_q, clr_idx_d;
  logic [3:0]           stall_cnt_q, stall_cnt_d;

  logic                 wb_gnt_p0, dbg_gnt_p0;
  logic [4:0]           wb_addr_p0, dbg_addr_p0;

  logic                 we_p1, we_d;
  logic [4:0]           waddr_p1, waddr_d;
  logic [DataWidth-1:0] wdata_p1, wdata_d;

  // Under RV32E only 16 registers exist, so addr[4] is dropped before use.
  assign wb_addr_p0  = rf.wb_addr_i & AddrMask;
  assign dbg_addr_p0 = rf.dbg_addr_i & AddrMask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      clr_idx_q   <= 5'd1;
      stall_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---- stage p0: clear sequencing, grant selection, write capture ----
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    stall_cnt_d = stall_cnt_q;
    wb_gnt_p0   = 1'b0;
    dbg_gnt_p0  = 1'b0;
    we_d        = 1'b0;
    waddr_d     = waddr_p1;
    wdata_d     = wdata_p1;

    unique case (state_q)
      CLR: begin
        we_d      = 1'b1;
        waddr_d   = clr_idx_q;
        wdata_d   = WordZeroVal;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == LastIdx) begin
          state_d   = ARB;
          clr_idx_d = 5'd1;
        end
      end

      ARB: begin
        if (rf.init_start_i) begin
          state_d   = CLR;
          clr_idx_d = 5'd1;
        end else if (rf.dbg_req_i && (stall_cnt_q == StallMax)) begin
          dbg_gnt_p0 = 1'b1;
        end else if (rf.wb_req_i) begin
          wb_gnt_p0 = 1'b1;
        end else if (rf.dbg_req_i) begin
          dbg_gnt_p0 = 1'b1;
        end

        // x0 is hardwired: a grant to it is acknowledged but never written.
        if (wb_gnt_p0) begin
          we_d    = (wb_addr_p0 != 5'd0);
          waddr_d = wb_addr_p0;
          wdata_d = rf.wb_data_i;
        end else if (dbg_gnt_p0) begin
          we_d    = (dbg_addr_p0 != 5'd0);
          waddr_d = dbg_addr_p0;
          wdata_d = rf.dbg_data_i;
        end

        if (rf.dbg_req_i && !dbg_gnt_p0) begin
          stall_cnt_d = (stall_cnt_q == StallMax) ? StallMax : stall_cnt_q + 4'd1;
        end else begin
          stall_cnt_d = 4'd0;
        end
      end

      default: state_d = ResetState;
    endcase
  end

  // ---- stage p1: registered W1 write port ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_p1    <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= '0;
    end else begin
      we_p1    <= we_d;
      waddr_p1 <= waddr_d;
      wdata_p1 <= wdata_d;
    end
  end

  assign rf.wb_gnt_o  = wb_gnt_p0;
  assign rf.dbg_gnt_o = dbg_gnt_p0;
  assign rf.busy_o    = (state_q == CLR);
  assign rf.we_a_o    = we_p1;
  assign rf.waddr_a_o = waddr_p1;
  assign rf.wdata_a_o = wdata_p1;

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Scoreboard bench: two controllers (RV32I/MaxStall=4 and RV32E/MaxStall=2)
// driven with directed and random traffic against a queue-based reference model.
module tb_ibex_rf_write_ctrl;
  localparam int DW = 32;

  localparam int M_QUIET  = 0;
  localparam int M_DIRECT = 1;
  localparam int M_CONT   = 2;
  localparam int M_RAND   = 3;

  typedef struct {
    logic          we;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wb_req [2];
  logic [4:0]    wb_addr [2];
  logic [DW-1:0] wb_data [2];
  logic          dbg_req [2];
  logic [4:0]    dbg_addr [2];
  logic [DW-1:0] dbg_data [2];
  logic          init [2];

  logic          wb_gnt_s [2];
  logic          dbg_gnt_s [2];
  logic          busy_s [2];
  logic          we_s [2];
  logic [4:0]    waddr_s [2];
  logic [DW-1:0] wdata_s [2];

  ibex_rf_write_ctrl_if #(.DataWidth(DW)) if0 ();
  ibex_rf_write_ctrl_if #(.DataWidth(DW)) if1 ();

  assign if0.wb_req_i     = wb_req[0];
  assign if0.wb_addr_i    = wb_addr[0];
  assign if0.wb_data_i    = wb_data[0];
  assign if0.dbg_req_i    = dbg_req[0];
  assign if0.dbg_addr_i   = dbg_addr[0];
  assign if0.dbg_data_i   = dbg_data[0];
  assign if0.init_start_i = init[0];
  assign if1.wb_req_i     = wb_req[1];
  assign if1.wb_addr_i    = wb_addr[1];
  assign if1.wb_data_i    = wb_data[1];
  assign if1.dbg_req_i    = dbg_req[1];
  assign if1.dbg_addr_i   = dbg_addr[1];
  assign if1.dbg_data_i   = dbg_data[1];
  assign if1.init_start_i = init[1];

  assign wb_gnt_s[0]  = if0.wb_gnt_o;
  assign dbg_gnt_s[0] = if0.dbg_gnt_o;
  assign busy_s[0]    = if0.busy_o;
  assign we_s[0]      = if0.we_a_o;
  assign waddr_s[0]   = if0.waddr_a_o;
  assign wdata_s[0]   = if0.wdata_a_o;
  assign wb_gnt_s[1]  = if1.wb_gnt_o;
  assign dbg_gnt_s[1] = if1.dbg_gnt_o;
  assign busy_s[1]    = if1.busy_o;
  assign we_s[1]      = if1.we_a_o;
  assign waddr_s[1]   = if1.waddr_a_o;
  assign wdata_s[1]   = if1.wdata_a_o;

  ibex_rf_write_ctrl #(
    .RV32E(1'b0), .DataWidth(DW), .WordZeroVal('0), .MaxStall(4), .InitOnReset(1'b1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rf(if0.slave)
  );

  ibex_rf_write_ctrl #(
    .RV32E(1'b1), .DataWidth(DW), .WordZeroVal('0), .MaxStall(2), .InitOnReset(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rf(if1.slave)
  );

  int checks = 0;
  int errors = 0;
  int mode   = M_QUIET;

  // Reference model state: clear-pass progress, starvation count, last W1 values.
  bit            m_busy [2];
  int            m_idx [2];
  int            m_stall [2];
  logic [4:0]    m_laddr [2];
  logic [DW-1:0] m_ldata [2];
  bit            last_wg [2];
  bit            last_dg [2];
  int            run [2];
  bit            run_valid [2];

  exp_t q0[$];
  exp_t q1[$];

  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int max_stall(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k]  = 1'b1;
    m_idx[k]   = 1;
    m_stall[k] = 0;
    m_laddr[k] = '0;
    m_ldata[k] = '0;
    last_wg[k] = 1'b0;
    last_dg[k] = 1'b0;
  endtask

  task automatic quiet(input int k);
    wb_req[k]   = 1'b0;
    wb_addr[k]  = '0;
    wb_data[k]  = '0;
    dbg_req[k]  = 1'b0;
    dbg_addr[k] = '0;
    dbg_data[k] = '0;
    init[k]     = 1'b0;
  endtask

  task automatic model_step(input int k, output bit ewg, output bit edg);
    exp_t e;
    int   a;
    ewg = 1'b0;
    edg = 1'b0;
    if (m_busy[k]) begin
      e.we       = 1'b1;
      e.addr     = 5'(m_idx[k]);
      e.data     = '0;
      m_laddr[k] = 5'(m_idx[k]);
      m_ldata[k] = '0;
      m_idx[k]++;
      if (m_idx[k] == nregs(k)) m_busy[k] = 1'b0;
    end else begin
      e.we   = 1'b0;
      e.addr = m_laddr[k];
      e.data = m_ldata[k];
      if (init[k]) begin
        m_busy[k] = 1'b1;
        m_idx[k]  = 1;
      end else begin
        if (dbg_req[k] && m_stall[k] == max_stall(k)) edg = 1'b1;
        else if (wb_req[k])                           ewg = 1'b1;
        else if (dbg_req[k])                          edg = 1'b1;
        if (ewg || edg) begin
          a          = (ewg ? int'(wb_addr[k]) : int'(dbg_addr[k])) % nregs(k);
          e.we       = (a != 0);
          e.addr     = 5'(a);
          e.data     = ewg ? wb_data[k] : dbg_data[k];
          m_laddr[k] = e.addr;
          m_ldata[k] = e.data;
        end
      end
      if (dbg_req[k] && !edg) m_stall[k] = (m_stall[k] < max_stall(k)) ? m_stall[k] + 1 : max_stall(k);
      else                    m_stall[k] = 0;
    end
    e.busy = m_busy[k];
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic gen(input int k);
    bit pend;
    init[k] = 1'b0;
    pend = wb_req[k] && !last_wg[k];
    if (pend && mode != M_QUIET && !(mode == M_RAND && $urandom_range(0, 15) == 0)) begin
      // hold the outstanding request unchanged
    end else if (pend || mode == M_DIRECT || mode == M_QUIET) begin
      wb_req[k] = 1'b0;
    end else begin
      wb_req[k]  = (mode == M_CONT) ? 1'b1 : 1'($urandom_range(0, 1));
      wb_addr[k] = 5'($urandom_range(0, 31));
      wb_data[k] = $urandom;
    end
    pend = dbg_req[k] && !last_dg[k];
    if (pend && mode != M_QUIET && !(mode == M_RAND && $urandom_range(0, 15) == 0)) begin
      // hold the outstanding request unchanged
    end else if (pend || mode == M_DIRECT || mode == M_QUIET) begin
      dbg_req[k] = 1'b0;
    end else begin
      dbg_req[k]  = (mode == M_CONT) ? 1'b1 : 1'($urandom_range(0, 1));
      dbg_addr[k] = 5'($urandom_range(0, 31));
      dbg_data[k] = $urandom;
    end
    if (mode == M_RAND && $urandom_range(0, 49) == 0) init[k] = 1'b1;
  endtask

  task automatic post();
    bit ewg, edg;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        last_wg[k] = 1'b0;
        last_dg[k] = 1'b0;
      end else begin
        model_step(k, ewg, edg);
        chk($sformatf("wb_gnt dut%0d", k), 64'(wb_gnt_s[k]), 64'(ewg));
        chk($sformatf("dbg_gnt dut%0d", k), 64'(dbg_gnt_s[k]), 64'(edg));
        if (mode == M_CONT) begin
          if (dbg_gnt_s[k]) begin
            if (run_valid[k]) chk($sformatf("starve_run dut%0d", k), 64'(run[k]), 64'(max_stall(k)));
            run[k]       = 0;
            run_valid[k] = 1'b1;
          end else if (wb_gnt_s[k]) begin
            run[k]++;
          end
        end
        last_wg[k] = ewg;
        last_dg[k] = edg;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    gen(0);
    gen(1);
    post();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && (wb_req[0] || wb_req[1] || dbg_req[0] || dbg_req[1])) begin
      step();
      c++;
    end
    chk("drain_pending", 64'(wb_req[0] | wb_req[1] | dbg_req[0] | dbg_req[1]), 64'(0));
  endtask

  // Monitor: every cycle the W1 port and busy flag are compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          chk($sformatf("rst_we dut%0d", k), 64'(we_s[k]), 64'(0));
          chk($sformatf("rst_waddr dut%0d", k), 64'(waddr_s[k]), 64'(0));
          chk($sformatf("rst_wdata dut%0d", k), 64'(wdata_s[k]), 64'(0));
          chk($sformatf("rst_busy dut%0d", k), 64'(busy_s[k]), 64'(1));
        end else if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow dut%0d: actual empty required entry", k);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("we dut%0d", k), 64'(we_s[k]), 64'(e.we));
          chk($sformatf("waddr dut%0d", k), 64'(waddr_s[k]), 64'(e.addr));
          chk($sformatf("wdata dut%0d", k), 64'(wdata_s[k]), 64'(e.data));
          chk($sformatf("busy dut%0d", k), 64'(busy_s[k]), 64'(e.busy));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      quiet(k);
      model_reset(k);
      run[k]       = 0;
      run_valid[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Release into the clear pass with writeback requests held off until it ends.
    rst_n      = 1'b1;
    mode       = M_DIRECT;
    wb_req[0]  = 1'b1;
    wb_addr[0] = 5'd5;
    wb_data[0] = 32'hDEADBEEF;
    wb_req[1]  = 1'b1;
    wb_addr[1] = 5'h13;
    wb_data[1] = 32'hA5A50013;
    post();
    drain(80);

    // Loader write to x0: acknowledged, never written.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dbg_req[k]  = 1'b1;
      dbg_addr[k] = 5'd0;
      dbg_data[k] = 32'h1234;
    end
    post();
    drain(10);

    // Clear request takes precedence over a pending writeback.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      init[k]    = 1'b1;
      wb_req[k]  = 1'b1;
      wb_addr[k] = 5'($urandom_range(1, 31));
      wb_data[k] = $urandom;
    end
    post();
    drain(60);

    mode = M_CONT;
    for (int k = 0; k < 2; k++) run_valid[k] = 1'b0;
    repeat (40) step();

    mode = M_QUIET;
    repeat (2) step();
    mode = M_RAND;
    repeat (600) step();

    // Reset in the middle of a clear pass.
    mode = M_QUIET;
    repeat (3) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      quiet(k);
      init[k] = 1'b1;
    end
    post();
    repeat (5) step();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      quiet(k);
      model_reset(k);
    end
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post();

    mode = M_RAND;
    repeat (200) step();
    mode = M_QUIET;
    repeat (40) step();

    @(posedge clk);
    #2;
    chk("sb_leftover dut0", 64'(q0.size()), 64'(0));
    chk("sb_leftover dut1", 64'(q1.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_write_ctrl.md
Name: ibex_rf_write_ctrl

Overview:
Write-port controller for the ibex flop-based register file (one write port W1).
- After reset, or on request, it sequences a clear pass that writes WordZeroVal to every architectural register.
- It then shares W1 between two requesters: core writeback (priority) and a debug/test loader.
- Starvation of the loader is bounded by a stall counter.
- Sits directly in front of the register file write port. Read ports are untouched.

Parameters:
RV32E, 0, 1 -> 16 registers (4-bit index used, addr[4] ignored on input and forced 0 on output); 0 -> 32 registers
DataWidth, 32, width of write data
WordZeroVal, '0, value written during clear pass
MaxStall, 4, consecutive denied loader cycles before loader is forced a grant (legal range 1..15)
InitOnReset, 1, 1 -> enter clear pass on reset release; 0 -> enter ARB directly

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
wb_req_i  input  1  writeback write request
wb_addr_i  input  5  writeback destination register
wb_data_i  input  DataWidth  writeback data
wb_gnt_o  output  1  writeback granted this cycle (combinational)
dbg_req_i  input  1  loader write request
dbg_addr_i  input  5  loader destination register
dbg_data_i  input  DataWidth  loader data
dbg_gnt_o  output  1  loader granted this cycle (combinational)
init_start_i  input  1  pulse: start a clear pass
busy_o  output  1  clear pass in progress (registered)
waddr_a_o  output  5  register file write address (registered)
wdata_a_o  output  DataWidth  register file write data (registered)
we_a_o  output  1  register file write enable (registered)

Behaviour:
- Reset (async, rst_ni=0):
  - we_a_o=0, waddr_a_o=0, wdata_a_o=0.
  - Stall counter=0, clear index=1.
  - State=CLR with busy_o=1 if InitOnReset, else state=ARB with busy_o=0.
- States: CLR, ARB.
- CLR:
  - Each cycle drive we_a_o=1, waddr_a_o=idx, wdata_a_o=WordZeroVal, then idx++.
  - Index runs 1..NumRegs-1 (x0 never written): 31 cycles for RV32I, 15 for RV32E.
  - On the write of the last index -> ARB. busy_o falls the same edge, so busy_o=0 the cycle after the last clear write.
  - wb_gnt_o=dbg_gnt_o=0 throughout. Requests are held off, not dropped.
  - init_start_i is ignored in CLR.
- ARB:
  - init_start_i=1 -> next state CLR, idx=1, busy_o=1. No grant is issued that cycle; init_start_i has priority over requests.
  - Otherwise grant selection:
    - If stall_cnt==MaxStall and dbg_req_i -> grant dbg.
    - Else if wb_req_i -> grant wb.
    - Else if dbg_req_i -> grant dbg.
    - At most one grant per cycle.
  - Granted write appears on W1 the next cycle (1-cycle latency): we_a_o=1, address and data captured at grant.
  - A grant to address 0 is acknowledged (gnt=1) but produces we_a_o=0 next cycle.
  - No grant -> we_a_o=0 next cycle; waddr_a_o/wdata_a_o hold their previous values.
- Stall counter:
  - Increments when dbg_req_i=1 and dbg_gnt_o=0 in ARB; saturates at MaxStall.
  - Clears on dbg grant or when dbg_req_i=0. Holds in CLR.
- Handshake: requester holds req/addr/data stable until gnt. A deasserted request without a grant is a legal abort.
- Reset mid-CLR: immediate return to reset values; the clear pass restarts from idx=1 after release (if InitOnReset).

Test Plan:
- Reset release, InitOnReset=1, RV32E=0 -> busy_o=1 for 31 cycles; W1 writes addr 1..31 with data 0 on consecutive cycles; then busy_o=0, we_a_o=0.
- ARB, wb_req_i=1 addr=5 data=0xDEADBEEF -> wb_gnt_o=1 same cycle; next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF.
- Both requesting continuously, MaxStall=4 -> wb granted 4 cycles, dbg granted on the 5th, counter back to 0, pattern repeats.
- dbg_req_i addr=0 data=0x1234 alone -> dbg_gnt_o=1; next cycle we_a_o=0.
- init_start_i in ARB with wb_req_i=1 -> no grant that cycle; CLR pass runs; wb granted on the first ARB cycle after busy_o falls.
- RV32E=1 -> clear covers addr 1..15 (15 cycles); wb_addr_i=0x13 is written to waddr_a_o=0x03.
